// File: rtl/uart_io_port_bridge_pkg.sv
// uart_io_pkg: register map, status constants and FSM encodings shared by the UART IO bridge
package uart_io_pkg;
   localparam logic [1:0] OFS_DATA   = 2'd0;
   localparam logic [1:0] OFS_RXRDY  = 2'd1;
   localparam logic [1:0] OFS_TXFULL = 2'd2;
   localparam logic [1:0] OFS_STAT   = 2'd3;
   localparam logic [7:0] STAT_TRUE  = 8'hFF;
   localparam logic [7:0] STAT_FALSE = 8'h00;
   localparam logic [7:0] UNMAPPED   = 8'hFF;
   typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
endpackage

// File: rtl/uart_io_port_bridge_if.sv
// uart_io_port_bridge_if: processor IO port bus (address, write data, strobes, read data)
interface uart_io_port_bridge_if;
   logic [7:0] IO_port_ID;
   logic [7:0] IO_write_data;
   logic       IO_write_strobe;
   logic       IO_read_strobe;
   logic [7:0] IO_read_data;
   modport master (output IO_port_ID, IO_write_data, IO_write_strobe, IO_read_strobe, input IO_read_data);
   modport slave  (input IO_port_ID, IO_write_data, IO_write_strobe, IO_read_strobe, output IO_read_data);
endinterface

// File: rtl/uart_io_port_bridge_fifo.sv
// io_sync_fifo: single-clock show-ahead FIFO; a pop frees the slot for a same-cycle push when full
module io_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                   clk100,
   input  logic                   reset,
   input  logic                   push,
   input  logic                   pop,
   input  logic [WIDTH-1:0]       din,
   output logic [WIDTH-1:0]       dout,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);
   localparam int AW = $clog2(DEPTH);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic do_push, do_pop;
   assign empty = count == '0;
   assign full = count == (AW+1)'(DEPTH);
   assign do_pop = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign dout = mem[rd_ptr];
   always_ff @(posedge clk100) if (do_push) mem[wr_ptr] <= din;
   always_ff @(posedge clk100) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop) rd_ptr <= rd_ptr + AW'(1);
         count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end
endmodule

// File: rtl/uart_io_port_bridge.sv
// uart_io_port_bridge: memory-mapped 8N1 UART on the processor IO port bus with RX/TX FIFOs
module uart_io_port_bridge
   import uart_io_pkg::*;
#(
   parameter int         BAUD_DIV   = 868,
   parameter int         FIFO_DEPTH = 16,
   parameter logic [7:0] BASE_PORT  = 8'h01
) (
   input  logic                  clk100,
   input  logic                  reset,
   uart_io_port_bridge_if.slave  bus,
   input  logic                  uart_rx,
   output logic                  uart_tx,
   output logic                  irq
);
   localparam int CW = $clog2(BAUD_DIV);
   localparam int NW = $clog2(FIFO_DEPTH) + 1;
   localparam logic [CW-1:0] BIT_END = CW'(BAUD_DIV - 1);
   localparam logic [CW-1:0] MID = CW'(BAUD_DIV / 2 - 1);
   logic rd_q, wr_q, rd_edge, wr_edge, mapped, stat_rd;
   logic [7:0] offset, reg_data, rx_dout, tx_dout, rx_shift, tx_shift;
   logic [1:0] ofs;
   logic rx_push, rx_ferr, rx_done, rx_pop, rx_full, rx_empty;
   logic tx_push, tx_pop, tx_full, tx_empty;
   logic [NW-1:0] rx_count, tx_count;
   logic overrun, framing_err, unused_count;
   logic [2:0] rx_sync, rx_bit, tx_bit;
   logic [CW-1:0] rx_cnt, tx_cnt;
   tx_state_t tx_state;
   rx_state_t rx_state;
   assign offset = bus.IO_port_ID - BASE_PORT;
   assign ofs = offset[1:0];
   assign mapped = offset[7:2] == '0;
   assign rd_edge = bus.IO_read_strobe && !rd_q;
   assign wr_edge = bus.IO_write_strobe && !wr_q;
   assign rx_pop = rd_edge && mapped && ofs == OFS_DATA;
   assign tx_push = wr_edge && mapped && ofs == OFS_DATA;
   assign stat_rd = rd_edge && mapped && ofs == OFS_STAT;
   assign reg_data = !mapped           ? UNMAPPED :
                     ofs == OFS_DATA   ? (rx_empty ? 8'h00 : rx_dout) :
                     ofs == OFS_RXRDY  ? (rx_empty ? STAT_FALSE : STAT_TRUE) :
                     ofs == OFS_TXFULL ? (tx_full ? STAT_TRUE : STAT_FALSE) :
                                         {overrun, framing_err, 6'b0};
   assign bus.IO_read_data = bus.IO_read_strobe ? reg_data : 8'h00;
   assign irq = rx_count != '0 || overrun || framing_err;
   assign unused_count = ^tx_count;
   io_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) rx_fifo (
      .clk100(clk100), .reset(reset), .push(rx_push), .pop(rx_pop), .din(rx_shift),
      .dout(rx_dout), .full(rx_full), .empty(rx_empty), .count(rx_count)
   );
   io_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) tx_fifo (
      .clk100(clk100), .reset(reset), .push(tx_push), .pop(tx_pop), .din(bus.IO_write_data),
      .dout(tx_dout), .full(tx_full), .empty(tx_empty), .count(tx_count)
   );
   // a flag set in the same cycle as a status read survives the clear
   always_ff @(posedge clk100) begin
      if (reset) begin
         rd_q <= 1'b0;
         wr_q <= 1'b0;
         overrun <= 1'b0;
         framing_err <= 1'b0;
      end else begin
         rd_q <= bus.IO_read_strobe;
         wr_q <= bus.IO_write_strobe;
         if (stat_rd) begin
            overrun <= 1'b0;
            framing_err <= 1'b0;
         end
         if (rx_push && rx_full && !rx_pop) overrun <= 1'b1;
         if (rx_ferr) framing_err <= 1'b1;
      end
   end
   assign tx_pop = !tx_empty && (tx_state == TX_IDLE || (tx_state == TX_STOP && tx_cnt == BIT_END));
   always_ff @(posedge clk100) begin
      if (reset) begin
         tx_state <= TX_IDLE;
         tx_cnt <= '0;
         tx_bit <= '0;
         tx_shift <= '0;
         uart_tx <= 1'b1;
      end else if (tx_pop) begin
         tx_state <= TX_START;
         tx_cnt <= '0;
         tx_shift <= tx_dout;
         uart_tx <= 1'b0;
      end else if (tx_state != TX_IDLE) begin
         tx_cnt <= tx_cnt == BIT_END ? '0 : tx_cnt + CW'(1);
         if (tx_cnt == BIT_END) begin
            case (tx_state)
               TX_START: begin
                  tx_state <= TX_DATA;
                  tx_bit <= '0;
                  uart_tx <= tx_shift[0];
               end
               TX_DATA: begin
                  tx_bit <= tx_bit + 3'd1;
                  tx_shift <= tx_shift >> 1;
                  tx_state <= tx_bit == 3'd7 ? TX_STOP : TX_DATA;
                  uart_tx <= tx_bit == 3'd7 ? 1'b1 : tx_shift[1];
               end
               default: tx_state <= TX_IDLE;
            endcase
         end
      end
   end
   // rx_sync[1] is the synchronised line, rx_sync[2] its previous value for edge detection
   assign rx_done = rx_state == RX_STOP && rx_cnt == BIT_END;
   assign rx_push = rx_done && rx_sync[1];
   assign rx_ferr = rx_done && !rx_sync[1];
   always_ff @(posedge clk100) begin
      if (reset) begin
         rx_sync <= 3'b111;
         rx_state <= RX_IDLE;
         rx_cnt <= '0;
         rx_bit <= '0;
         rx_shift <= '0;
      end else begin
         rx_sync <= {rx_sync[1:0], uart_rx};
         rx_cnt <= rx_cnt + CW'(1);
         case (rx_state)
            RX_IDLE: begin
               rx_cnt <= '0;
               if (rx_sync[2] && !rx_sync[1]) rx_state <= RX_START;
            end
            RX_START: if (rx_cnt == MID) begin
               rx_cnt <= '0;
               rx_bit <= '0;
               rx_state <= rx_sync[1] ? RX_IDLE : RX_DATA;
            end
            RX_DATA: if (rx_cnt == BIT_END) begin
               rx_cnt <= '0;
               rx_bit <= rx_bit + 3'd1;
               rx_shift <= {rx_sync[1], rx_shift[7:1]};
               if (rx_bit == 3'd7) rx_state <= RX_STOP;
            end
            default: if (rx_cnt == BIT_END) rx_state <= RX_IDLE;
         endcase
      end
   end
endmodule
